// File: rtl/oka_pkg.sv
// Shared definitions for the sequential overlap-free Karatsuba GF(2)[x] multiplier:
// FSM encoding, width limits and a bit-serial carry-less reference product.
package oka_pkg;

  localparam int MIN_W   = 4;
  localparam int MAX_W   = 64;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    COMB = 3'd4,
    DONE = 3'd5
  } oka_state_e;

  // Bit-serial shift-and-xor product of operands up to MAX_W bits (zero-extend narrower ones).
  function automatic logic [2*MAX_W-2:0] oka_ref(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    logic [2*MAX_W-2:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (b[i]) begin
        acc = acc ^ ({{(MAX_W-1){1'b0}}, a} << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/oka_clmul_half.sv
// Combinational H x H schoolbook carry-less multiplier; the single shared
// partial-product engine of oka_seq_mul.
module oka_clmul_half #(
  parameter int H = 32
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  output logic [2*H-2:0] p
);

  // Each set bit of b contributes a shifted copy of a; GF(2) addition is XOR.
  always_comb begin
    p = '0;
    for (int i = 0; i < H; i++) begin
      p = p ^ (({{(H-1){1'b0}}, a} << i) & {(2*H-1){b[i]}});
    end
  end

endmodule

// File: rtl/oka_seq_mul.sv
// Sequential overlap-free Karatsuba multiplier over GF(2)[x]: one H x H core is
// time-shared across the three partial products, with valid/ready on both sides.
module oka_seq_mul
  import oka_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output logic           busy
);

  localparam int H = W / 2;

  localparam logic [STATE_W-1:0] S_IDLE = IDLE;
  localparam logic [STATE_W-1:0] S_M0   = M0;
  localparam logic [STATE_W-1:0] S_M1   = M1;
  localparam logic [STATE_W-1:0] S_M2   = M2;
  localparam logic [STATE_W-1:0] S_COMB = COMB;
  localparam logic [STATE_W-1:0] S_DONE = DONE;

  if (((W % 2) != 0) || (W < MIN_W)) begin : g_bad_width
    $fatal(1, "oka_seq_mul: W must be even and at least %0d", MIN_W);
  end

  logic [STATE_W-1:0] state;
  logic [H-1:0]       al, ah, bl, bh;
  logic [2*H-2:0]     z0, z1, z2;
  logic [H-1:0]       mul_a, mul_b;
  logic [2*H-2:0]     prod;
  logic [2*H-2:0]     mid;
  logic [2*W-2:0]     comb;
  logic               accept;

  // in_ready deliberately looks through out_ready so a DONE hand-off can overlap a new accept.
  assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // Operand mux of the shared core, selected by the current partial-product step.
  always_comb begin
    case (state)
      S_M0: begin
        mul_a = al;
        mul_b = bl;
      end
      S_M1: begin
        mul_a = al ^ ah;
        mul_b = bl ^ bh;
      end
      S_M2: begin
        mul_a = ah;
        mul_b = bh;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  oka_clmul_half #(.H(H)) u_clmul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Overlap-free recombination: y = z0 + (z0+z1+z2)x^H + z2 x^W.
  always_comb begin
    mid  = z0 ^ z1 ^ z2;
    comb = {{W{1'b0}}, z0} ^ ({{W{1'b0}}, mid} << H) ^ ({{W{1'b0}}, z2} << W);
  end

  // FSM sequencing and output-valid handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_M0;
          end
        end
        S_M0:   state <= S_M1;
        S_M1:   state <= S_M2;
        S_M2:   state <= S_COMB;
        S_COMB: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? S_M0 : S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Operand halves are captured only on an accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al <= '0;
      ah <= '0;
      bl <= '0;
      bh <= '0;
    end else if (accept) begin
      al <= a[H-1:0];
      ah <= a[W-1:H];
      bl <= b[H-1:0];
      bh <= b[W-1:H];
    end
  end

  // Partial-product registers, one per multiply step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0 <= '0;
      z1 <= '0;
      z2 <= '0;
    end else begin
      case (state)
        S_M0:    z0 <= prod;
        S_M1:    z1 <= prod;
        S_M2:    z2 <= prod;
        default: z0 <= z0;
      endcase
    end
  end

  // Result register, loaded once per product and held through DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (state == S_COMB) begin
      y <= comb;
    end
  end

endmodule
